// File: rtl/fourbit_serial_subtractor.sv
// Bit-serial 4-bit subtractor: diff = a - b - bin (mod 16), bout = unsigned borrow.
// One bit is resolved per clock, LSB first, through a three-state controller
// (IDLE -> SUB x4 -> DONE). The result and the status flags are all registered.
module fourbit_serial_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] sa;       // minuend shift register, LSB is the bit in flight
  logic [3:0] sb;       // subtrahend shift register
  logic [3:0] res;      // result register, filled from the MSB side
  logic       br;       // running borrow
  logic [1:0] cnt;      // bit index of the current SUB edge
  logic       d;
  logic       br_next;

  // One-bit full subtractor on the current LSBs and running borrow.
  // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Controller, datapath shift registers and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, exactly like the flops they become.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= 4'd0;
      sb    <= 4'd0;
      res   <= 4'd0;
      br    <= 1'b0;
      cnt   <= 2'd0;
      diff  <= 4'd0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            res   <= 4'd0;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB: begin
          sa  <= {1'b0, sa[3:1]};
          sb  <= {1'b0, sb[3:1]};
          br  <= br_next;
          res <= {d, res[3:1]};
          cnt <= cnt + 2'd1;
          // Fourth bit: publish the full result straight from the shifter.
          if (cnt == 2'd3) begin
            diff  <= {d, res[3:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
